// File: rtl/scan_display_pkg.sv
// Shared segment patterns, FSM encoding and sizing helpers for the scanned display.
// Combinational only, so no latency and no flow control.
// Used by both scan_display_ctrl and bin2bcd_seq.
package scan_display_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CONV   = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;

    // bit7 = dp, bits6..0 = a..g
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h01;
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
        8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B
    };

    function automatic int bcd_width(input int digits);
        return digits * 4;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] s;
        s = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (nib == 4'(i)) begin
                s = SEG_DIGIT[i];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one binary bit (MSB first) per bit_vld cycle.
// Latency: done pulses the cycle after the VAL_W-th bit; bcd holds until the next start.
// No backpressure: the caller paces bits and must consume bcd while done is high.
module bin2bcd_seq
    import scan_display_pkg::*;
#(
    parameter int VAL_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                        clk_scan,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        bit_vld,
    input  logic                        bit_in,
    output logic                        done,
    output logic [bcd_width(DIGITS)-1:0] bcd
);

    localparam int BCD_W = bcd_width(DIGITS);
    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [BCD_W-1:0] base;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // start folds the clear into the first shift so channels run back to back
    always_comb begin
        base = start ? '0 : bcd;
        adj  = '0;
        for (int d = 0; d < DIGITS; d++) begin
            adj[d*4 +: 4] = (base[d*4 +: 4] >= 4'd5) ? base[d*4 +: 4] + 4'd3 : base[d*4 +: 4];
        end
        cnt_next = start ? CNT_W'(1) : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_scan or negedge rst_n) begin
        if (!rst_n) begin
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (bit_vld) begin
            bcd  <= {adj[BCD_W-2:0], bit_in};
            cnt  <= cnt_next;
            done <= (cnt_next == CNT_W'(VAL_W));
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/scan_display_ctrl.sv
// Multiplexed 7-segment controller: load -> serial BCD convert -> atomic commit -> 1 digit/clk scan.
// Latency: busy for NUM_CH*VAL_W+1 cycles after load; new digits appear from the slot after commit.
// No backpressure: load while busy is dropped. Optional blinking under `SCAN_BLINK_EN.
module scan_display_ctrl
    import scan_display_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DIGITS   = 2,
    parameter int VAL_W    = 6,
    parameter int LZ_BLANK = 1
`ifdef SCAN_BLINK_EN
    ,
    parameter int BLINK_DIV = 500
`endif
) (
    input  logic                       clk_scan,
    input  logic                       rst_n,
    input  logic [NUM_CH*VAL_W-1:0]    values,
    input  logic                       load,
`ifdef SCAN_BLINK_EN
    input  logic [NUM_CH-1:0]          blink,
`endif
    output logic                       busy,
    output logic [NUM_CH*DIGITS-1:0]   an,
    output logic [7:0]                 seg
);

    localparam int BCD_W = bcd_width(DIGITS);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BIT_W = $clog2(VAL_W + 1);
    localparam int AN_W  = NUM_CH * DIGITS;
    localparam logic [63:0] OVF_LIM = pow10(DIGITS);

    state_t             state;
    logic [CH_W-1:0]    ch_idx;
    logic [BIT_W-1:0]   bit_cnt;
    logic [VAL_W-1:0]   shadow   [NUM_CH];
    logic [BCD_W-1:0]   res      [NUM_CH];
    logic [BCD_W-1:0]   disp_bcd [NUM_CH];
    logic [NUM_CH-1:0]  disp_ovf;

    logic               eng_start;
    logic               eng_vld;
    logic               eng_bit;
    logic               eng_done;
    logic [BCD_W-1:0]   eng_bcd;
    logic [BIT_W-1:0]   bit_sel;

    assign busy      = (state != ST_IDLE);
    assign eng_vld   = (state == ST_CONV);
    assign eng_start = (bit_cnt == '0);
    assign bit_sel   = BIT_W'(VAL_W - 1) - bit_cnt;
    assign eng_bit   = shadow[ch_idx][bit_sel];

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_scan (clk_scan),
        .rst_n    (rst_n),
        .start    (eng_start),
        .bit_vld  (eng_vld),
        .bit_in   (eng_bit),
        .done     (eng_done),
        .bcd      (eng_bcd)
    );

    always_ff @(posedge clk_scan or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ch_idx   <= '0;
            bit_cnt  <= '0;
            disp_ovf <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow[c]   <= '0;
                res[c]      <= '0;
                disp_bcd[c] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            shadow[c] <= values[c*VAL_W +: VAL_W];
                        end
                        ch_idx  <= '0;
                        bit_cnt <= '0;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    // previous channel finished last cycle; ch_idx has already moved on
                    if (eng_done) begin
                        res[ch_idx - CH_W'(1)] <= eng_bcd;
                    end
                    if (bit_cnt == BIT_W'(VAL_W - 1)) begin
                        bit_cnt <= '0;
                        if (ch_idx == CH_W'(NUM_CH - 1)) begin
                            state <= ST_COMMIT;
                        end else begin
                            ch_idx <= ch_idx + CH_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    // last channel is still sitting in the engine
                    for (int c = 0; c < NUM_CH; c++) begin
                        disp_bcd[c] <= (c == NUM_CH - 1) ? eng_bcd : res[c];
                        disp_ovf[c] <= (64'(shadow[c]) >= OVF_LIM);
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [CH_W-1:0]  scan_ch;
    logic [DG_W-1:0]  scan_dig;
    logic [BCD_W-1:0] cur_bcd;
    logic [3:0]       cur_nib;
    logic             upper_nz;
    logic             blank;
    logic [7:0]       seg_next;
    logic [AN_W-1:0]  an_next;
    int               dig_i;
    int               slot_i;

`ifdef SCAN_BLINK_EN
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BL_W-1:0] blink_cnt;
    logic            blink_on;

    always_ff @(posedge clk_scan or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end
`endif

    always_comb begin
        dig_i    = int'(scan_dig);
        slot_i   = int'(scan_ch) * DIGITS + dig_i;
        cur_bcd  = disp_bcd[scan_ch];
        cur_nib  = cur_bcd[dig_i*4 +: 4];
        upper_nz = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (d >= dig_i && cur_bcd[d*4 +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end
        blank   = (LZ_BLANK != 0) && (dig_i != 0) && !upper_nz;
        an_next = AN_W'(1) << slot_i;
        if (disp_ovf[scan_ch]) begin
            seg_next = SEG_DASH;
        end else if (blank) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = seg_decode(cur_nib);
        end
`ifdef SCAN_BLINK_EN
        if (!blink_on && blink[scan_ch]) begin
            seg_next = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk_scan or negedge rst_n) begin
        if (!rst_n) begin
            scan_ch  <= '0;
            scan_dig <= '0;
            an       <= '0;
            seg      <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            if (scan_dig == DG_W'(DIGITS - 1)) begin
                scan_dig <= '0;
                scan_ch  <= (scan_ch == CH_W'(NUM_CH - 1)) ? '0 : scan_ch + CH_W'(1);
            end else begin
                scan_dig <= scan_dig + DG_W'(1);
            end
        end
    end

endmodule
